// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide sequencer: operand width, MIPS funct codes, FSM states.
package mdu_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

    function automatic logic is_mdu_code(input logic [5:0] op);
        return op inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration on the {acc, q} pair: LSB-first shift-add multiply or
// MSB-first restoring divide (q collects quotient bits, acc holds the partial remainder).
module mdu_step #(
    parameter int W = 32
) (
    input  logic [2*W-1:0] i_acc_q,
    input  logic [W-1:0]   i_operand,
    input  logic           i_op_is_div,
    output logic [2*W-1:0] o_acc_q
);

    logic [W-1:0] w_acc;
    logic [W-1:0] w_q;
    logic [W:0]   w_sum;
    logic [W:0]   w_trial;
    logic [W-1:0] w_diff;

    assign w_acc = i_acc_q[2*W-1:W];
    assign w_q   = i_acc_q[W-1:0];

    // The partial remainder stays below the divisor, so a W-bit difference is exact
    // whenever the trial subtraction succeeds.
    always_comb begin
        w_sum   = {1'b0, w_acc} + (w_q[0] ? {1'b0, i_operand} : '0);
        w_trial = {w_acc, w_q[W-1]};
        w_diff  = w_trial[W-1:0] - i_operand;
        o_acc_q = {w_sum, w_q[W-1:1]};
        if (i_op_is_div) begin
            if (w_trial >= {1'b0, i_operand}) begin
                o_acc_q = {w_diff, w_q[W-2:0], 1'b1};
            end else begin
                o_acc_q = {w_trial[W-1:0], w_q[W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mult_div_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; optional macro MDU_DIVZERO_DETECT_EN adds div_zero.
// state | meaning:  IDLE | accepts ops, serves MF/MT  -  CALC | XLEN radix-2 steps  -  FIX | sign fix, write HI/LO
module mult_div_sequencer
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_flush,
    input  logic [5:0]      alu_ctrl_op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [XLEN-1:0] hilo_rdata,
    output logic            mdu_stall,
    output logic            mdu_busy,
    output logic            mdu_done
`ifdef MDU_DIVZERO_DETECT_EN
    ,
    output logic            div_zero
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_e            r_state, w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0] r_acc_q, w_step_acc_q, w_prod;
    logic [XLEN-1:0]   r_opb, r_hi, r_lo;
    logic [XLEN-1:0]   w_abs_a, w_abs_b, w_quo, w_rem;
    logic              r_is_div, r_neg_q, r_neg_r, r_done;
    logic              w_is_muldiv, w_is_div, w_signed, w_a_neg, w_b_neg;
    logic              w_start, w_mt_ok, w_div_by_zero;

    assign w_is_muldiv = alu_ctrl_op inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
    assign w_is_div    = (alu_ctrl_op == FN_DIV) || (alu_ctrl_op == FN_DIVU);
    assign w_signed    = (alu_ctrl_op == FN_MULT) || (alu_ctrl_op == FN_DIV);
    assign w_a_neg     = w_signed & src_a[XLEN-1];
    assign w_b_neg     = w_signed & src_b[XLEN-1];
    assign w_abs_a     = w_a_neg ? -src_a : src_a;
    assign w_abs_b     = w_b_neg ? -src_b : src_b;
    assign w_mt_ok     = (r_state == IDLE) & ex_valid & ~ex_flush;
    assign w_start     = w_mt_ok & w_is_muldiv;

`ifdef MDU_DIVZERO_DETECT_EN
    assign w_div_by_zero = w_is_div & (src_b == '0);
`else
    assign w_div_by_zero = 1'b0;
`endif

    assign mdu_busy  = (r_state != IDLE);
    assign mdu_stall = ex_valid & mdu_busy & is_mdu_code(alu_ctrl_op);
    assign mdu_done  = r_done;

    always_comb begin
        hilo_rdata = '0;
        case (alu_ctrl_op)
            FN_MFHI: hilo_rdata = r_hi;
            FN_MFLO: hilo_rdata = r_lo;
            default: hilo_rdata = '0;
        endcase
    end

    mdu_step #(.W(XLEN)) u_step (
        .i_acc_q     (r_acc_q),
        .i_operand   (r_opb),
        .i_op_is_div (r_is_div),
        .o_acc_q     (w_step_acc_q)
    );

    assign w_prod = r_neg_q ? -r_acc_q : r_acc_q;
    assign w_quo  = r_neg_q ? -r_acc_q[XLEN-1:0] : r_acc_q[XLEN-1:0];
    assign w_rem  = r_neg_r ? -r_acc_q[2*XLEN-1:XLEN] : r_acc_q[2*XLEN-1:XLEN];

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_start) w_next_state = w_div_by_zero ? FIX : CALC;
            CALC: begin
                if (ex_flush)              w_next_state = IDLE;
                else if (r_cnt == CNT_LAST) w_next_state = FIX;
            end
            FIX:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc_q  <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_cnt    <= '0;
                        r_is_div <= w_is_div;
                        r_opb    <= w_abs_b;
                        if (w_div_by_zero) begin
                            // Early-out result is final: HI=dividend, LO=all-ones, no sign fix.
                            r_acc_q <= {src_a, {XLEN{1'b1}}};
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else begin
                            r_acc_q <= {{XLEN{1'b0}}, w_abs_a};
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                        end
                    end else if (w_mt_ok && alu_ctrl_op == FN_MTHI) begin
                        r_hi <= src_a;
                    end else if (w_mt_ok && alu_ctrl_op == FN_MTLO) begin
                        r_lo <= src_a;
                    end
                end
                CALC: begin
                    if (!ex_flush) begin
                        r_acc_q <= w_step_acc_q;
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                FIX: begin
                    if (!ex_flush) begin
                        r_hi   <= r_is_div ? w_rem : w_prod[2*XLEN-1:XLEN];
                        r_lo   <= r_is_div ? w_quo : w_prod[XLEN-1:0];
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MDU_DIVZERO_DETECT_EN
    logic r_dz_op, r_div_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dz_op    <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_div_zero <= 1'b0;
            if (w_start)                         r_dz_op    <= w_div_by_zero;
            if (r_state == FIX && !ex_flush)     r_div_zero <= r_dz_op;
        end
    end

    assign div_zero = r_div_zero;
`endif

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed bench for mult_div_sequencer: reference results queued at issue, checked at mdu_done.
module tb_mult_div_sequencer;
    import mdu_pkg::*;

    localparam logic [5:0] FN_ADD = 6'b100000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_flush = 1'b0;
    logic [5:0]  alu_ctrl_op = FN_ADD;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic [31:0] hilo_rdata;
    logic        mdu_stall, mdu_busy, mdu_done;
`ifdef MDU_DIVZERO_DETECT_EN
    logic        div_zero;
`endif

    int          n_assert = 0;
    int          n_fail = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    mult_div_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .ex_flush    (ex_flush),
        .alu_ctrl_op (alu_ctrl_op),
        .src_a       (src_a),
        .src_b       (src_b),
        .hilo_rdata  (hilo_rdata),
        .mdu_stall   (mdu_stall),
        .mdu_busy    (mdu_busy),
        .mdu_done    (mdu_done)
`ifdef MDU_DIVZERO_DETECT_EN
        ,
        .div_zero    (div_zero)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference {HI, LO} from plain SV arithmetic, independent of the iterative datapath.
    function automatic logic [63:0] model(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, p;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (op)
            FN_MULT: begin
                p = sa * sb;
                r = p;
            end
            FN_MULTU: r = {32'b0, a} * {32'b0, b};
            FN_DIVU:  r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            FN_DIV: begin
                if (b == 0) begin
`ifdef MDU_DIVZERO_DETECT_EN
                    r = {a, 32'hFFFF_FFFF};
`else
                    r = {a, (a[31] ? 32'h1 : 32'hFFFF_FFFF)};
`endif
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r = {32'h0, 32'h8000_0000};
                end else begin
                    r = {32'(sa % sb), 32'(sa / sb)};
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int op_latency(input logic [5:0] op, input logic [31:0] b);
`ifdef MDU_DIVZERO_DETECT_EN
        if ((op == FN_DIV || op == FN_DIVU) && b == 0) return 2;
`endif
        return 34;
    endfunction

    task automatic read_hilo(input string tag, input logic [63:0] exp);
        alu_ctrl_op = FN_MFHI;
        #1 check({tag, " HI"}, hilo_rdata, exp[63:32]);
        alu_ctrl_op = FN_MFLO;
        #1 check({tag, " LO"}, hilo_rdata, exp[31:0]);
        alu_ctrl_op = FN_ADD;
    endtask

    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int          lat;
        logic [63:0] exp;
        @(negedge clk);
        ex_valid = 1'b1; alu_ctrl_op = op; src_a = a; src_b = b;
        sb_q.push_back(model(op, a, b));
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check({tag, " busy@1"}, 32'(mdu_busy), 32'd1);
                ex_valid = 1'b0; alu_ctrl_op = FN_ADD;
            end
            if (mdu_done) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, lat, op_latency(op, b));
        check({tag, " busy@done"}, 32'(mdu_busy), 32'd0);
`ifdef MDU_DIVZERO_DETECT_EN
        check({tag, " div_zero"}, 32'(div_zero),
              32'((op == FN_DIV || op == FN_DIVU) && b == 0));
`endif
        check({tag, " sb depth"}, 32'(sb_q.size()), 32'd1);
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
        read_hilo(tag, exp);
        @(negedge clk);
        check({tag, " done 1-cycle"}, 32'(mdu_done), 32'd0);
    endtask

    initial begin
        int          cnt;
        logic [63:0] exp;

        repeat (2) @(negedge clk);
        check("rst busy", 32'(mdu_busy), 32'd0);
        check("rst done", 32'(mdu_done), 32'd0);
        check("rst stall", 32'(mdu_stall), 32'd0);
        read_hilo("rst", 64'h0);
        rst_n = 1'b1;

        run_op("mult -2*3", FN_MULT, 32'hFFFF_FFFE, 32'd3);
        run_op("divu 100/7", FN_DIVU, 32'd100, 32'd7);
        run_op("div -7/2", FN_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("div min/-1", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("multu max", FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult mixed", FN_MULT, 32'h1234_5678, 32'hFFFF_FF9C);
        run_op("div neg divisor", FN_DIV, 32'd12345678, 32'hFFFF_FF9C);
        run_op("divu by 0", FN_DIVU, 32'hCAFE_0001, 32'd0);
        run_op("div neg by 0", FN_DIV, 32'hFFFF_FFF7, 32'd0);

        // MULTU followed by a dependent MFLO that must stall until busy drops
        @(negedge clk);
        ex_valid = 1'b1; alu_ctrl_op = FN_MULTU; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0;
        sb_q.push_back(model(FN_MULTU, 32'h1234_5678, 32'h9ABC_DEF0));
        @(negedge clk);
        alu_ctrl_op = FN_MFLO;
        cnt = 0;
        for (int k = 1; k <= 100; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            if (!mdu_stall) break;
            cnt++;
        end
        check("stall cycles", cnt, 33);
        check("stall busy", 32'(mdu_busy), 32'd0);
        check("stall done", 32'(mdu_done), 32'd1);
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
        check("stall MFLO", hilo_rdata, exp[31:0]);
        ex_valid = 1'b0; alu_ctrl_op = FN_ADD;

        // MTHI / MTLO, plus MF read with valid in IDLE must not stall
        @(negedge clk);
        ex_valid = 1'b1; alu_ctrl_op = FN_MTHI; src_a = 32'hAAAA_5555;
        @(negedge clk);
        alu_ctrl_op = FN_MTLO; src_a = 32'h5A5A_A5A5;
        @(negedge clk);
        alu_ctrl_op = FN_MFHI;
        #1 check("idle no stall", 32'(mdu_stall), 32'd0);
        ex_valid = 1'b0;
        read_hilo("mt", 64'hAAAA_5555_5A5A_A5A5);

        // DIV aborted by flush at cycle 10
        @(negedge clk);
        ex_valid = 1'b1; alu_ctrl_op = FN_DIV; src_a = 32'd1000; src_b = 32'd3;
        cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                ex_valid = 1'b0; alu_ctrl_op = FN_ADD;
            end
            if (mdu_done) cnt++;
            if (k == 10) begin
                check("flush busy@10", 32'(mdu_busy), 32'd1);
                ex_flush = 1'b1;
            end
            if (k == 11) begin
                check("flush busy@11", 32'(mdu_busy), 32'd0);
                ex_flush = 1'b0;
            end
        end
        check("flush no done", cnt, 0);
        read_hilo("flush keep", 64'hAAAA_5555_5A5A_A5A5);

        // Flush in IDLE suppresses MTHI and start
        @(negedge clk);
        ex_valid = 1'b1; ex_flush = 1'b1; alu_ctrl_op = FN_MTHI; src_a = 32'h1111_2222;
        @(negedge clk);
        alu_ctrl_op = FN_MULT;
        @(negedge clk);
        check("idle flush busy", 32'(mdu_busy), 32'd0);
        ex_valid = 1'b0; ex_flush = 1'b0;
        read_hilo("idle flush", 64'hAAAA_5555_5A5A_A5A5);

        // Reset in the middle of an operation
        @(negedge clk);
        ex_valid = 1'b1; alu_ctrl_op = FN_MULT; src_a = 32'd5; src_b = 32'd7;
        @(negedge clk);
        ex_valid = 1'b0; alu_ctrl_op = FN_ADD;
        repeat (3) @(negedge clk);
        check("pre-reset busy", 32'(mdu_busy), 32'd1);
        rst_n = 1'b0;
        #1 check("mid reset busy", 32'(mdu_busy), 32'd0);
        read_hilo("mid reset", 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset done", 32'(mdu_done), 32'd0);
        check("sb empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
